instr_fetch_queue: RTL

Instruction fetch front end that drives the fetch PC and issues requests to a variable-latency instruction memory. It buffers returned instructions with their PCs in a small prefetch queue and presents them to the IF/ID pipeline register through a valid/ready handshake. It handles redirects from branch/jump resolution by flushing the queue and discarding in-flight responses, and it flags misaligned redirect targets.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/instr_fetch_queue.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end.
//   fetch_entry_t : one prefetch queue entry {pc, instr}
//   fetch_state_e : fetch FSM states (RUN fetching, FAULT after misaligned redirect)
//   INSTR_BYTES   : size of one instruction word in bytes
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, push_data : write one entry (ignored during flush)
//   pop          : remove the head entry (ignored when empty or during flush)
//   flush        : drop every entry; wins over push and pop
//   head         : registered head entry (all-zero after reset)
//   empty, count : occupancy status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop, full;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    do_push  = push && !flush;
    do_pop   = pop && (count_q != '0) && !flush;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // The fetch credit rule makes this unreachable; a hit means the credit logic is broken.
  push_into_full_a : assert property (@(posedge clk) disable iff (!rst_n)
                                      !(push && !flush && full));

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: drives the fetch PC toward a variable-latency
// instruction memory, buffers returned words with their PCs in a prefetch
// queue and hands them to decode over a valid/ready handshake. Redirects
// flush the queue and discard in-flight responses.
// Ports:
//   clk, resetn                       : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         : fetch request channel (word aligned)
//   imem_rsp_valid/data               : in-order responses, no backpressure
//   redirect_valid/redirect_pc        : single-cycle PC redirect from EX
//   id_valid/id_ready/id_pc/id_instr  : queue head toward IF/ID
//   misaligned_err                    : sticky, last redirect target not word aligned
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        misaligned_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] kill_cnt_q, kill_cnt_d;
  logic          misaligned_q, misaligned_d;

  logic [CW-1:0] q_count;
  logic          q_empty;
  fetch_entry_t  q_head;
  fetch_entry_t  push_entry;
  logic [CW:0]   in_use;
  logic          issue, keep_rsp, pop;

  always_comb begin
    // Queued entries plus requests in flight may never exceed the queue size,
    // so every response is guaranteed a slot.
    in_use         = {1'b0, q_count} + {1'b0, outstanding_q};
    imem_req_valid = resetn && (state_q == RUN) && !redirect_valid &&
                     (in_use < (CW+1)'(DEPTH));
    issue          = imem_req_valid && imem_req_ready;
    keep_rsp       = imem_rsp_valid && (kill_cnt_q == '0) && !redirect_valid;
    pop            = !q_empty && id_ready;
    push_entry     = '{pc: rsp_pc_q, instr: imem_rsp_data};

    state_d       = state_q;
    misaligned_d  = misaligned_q;
    fetch_pc_d    = issue ? fetch_pc_q + 32'(INSTR_BYTES) : fetch_pc_q;
    rsp_pc_d      = keep_rsp ? rsp_pc_q + 32'(INSTR_BYTES) : rsp_pc_q;
    outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rsp_valid);
    kill_cnt_d    = kill_cnt_q;
    if (imem_rsp_valid && (kill_cnt_q != '0)) begin
      kill_cnt_d = kill_cnt_q - 1'b1;
    end

    if (redirect_valid) begin
      // Nothing issues in a redirect cycle, so outstanding_d already excludes
      // a response landing now; that response is dropped here and not killed twice.
      kill_cnt_d = outstanding_d;
      rsp_pc_d   = redirect_pc;
      if (redirect_pc[1:0] == 2'b00) begin
        fetch_pc_d   = redirect_pc;
        state_d      = RUN;
        misaligned_d = 1'b0;
      end else begin
        state_d      = FAULT;
        misaligned_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      kill_cnt_q    <= kill_cnt_d;
      misaligned_q  <= misaligned_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (keep_rsp),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign imem_req_addr  = fetch_pc_q;
  assign id_valid       = !q_empty;
  assign id_pc          = q_head.pc;
  assign id_instr       = q_head.instr;
  assign misaligned_err = misaligned_q;

endmodule
